// File: rtl/box_plotter.sv
// Square rasteriser for a VGA framebuffer: one pixel per clock, row-major.
// Define BOX_PLOTTER_CLIP_EN to suppress plot for pixels off the 160x120 screen.
module box_plotter #(
  parameter int BOX_SIZE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_color,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_color,
  output logic       plot,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  // Counters are 4 bits wide because the largest legal square is 16 pixels.
  localparam logic [3:0] LAST = 4'(BOX_SIZE - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cx;
  logic [3:0] cy;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] color;
  logic       accept;
  logic       last_pixel;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       pix_visible;

  assign accept     = (state == IDLE) && req_valid;
  assign last_pixel = (cx == LAST) && (cy == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = DRAW;
      DRAW:    if (last_pixel) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields and raster counters; reset takes priority over a request.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_x <= '0;
      base_y <= '0;
      color  <= '0;
      cx     <= '0;
      cy     <= '0;
    end else if (accept) begin
      base_x <= req_x;
      base_y <= req_y;
      color  <= req_color;
      cx     <= '0;
      cy     <= '0;
    end else if (state == DRAW) begin
      if (cx == LAST) begin
        cx <= '0;
        cy <= cy + 4'd1;
      end else begin
        cx <= cx + 4'd1;
      end
    end
  end

`ifdef BOX_PLOTTER_CLIP_EN
  // Unwrapped sums decide visibility; the wrapped low bits still go out.
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  assign sum_x       = {1'b0, base_x} + {5'b0, cx};
  assign sum_y       = {1'b0, base_y} + {4'b0, cy};
  assign pix_x       = sum_x[7:0];
  assign pix_y       = sum_y[6:0];
  assign pix_visible = (sum_x < 9'd160) && (sum_y < 8'd120);
`else
  assign pix_x       = base_x + {4'b0, cx};
  assign pix_y       = base_y + {3'b0, cy};
  assign pix_visible = 1'b1;
`endif

  always_comb begin
    req_ready = 1'b0;
    plot      = 1'b0;
    done      = 1'b0;
    out_x     = '0;
    out_y     = '0;
    out_color = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      DRAW: begin
        plot      = pix_visible;
        out_x     = pix_x;
        out_y     = pix_y;
        out_color = color;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/box_plotter.md
BOX_PLOTTER -- requirements
Module: box_plotter

Interface
REQ-001 The block SHALL have parameter BOX_SIZE, default 4, meaning the square edge length in pixels (legal range 1..16).
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid  input  1  draw request present.
REQ-005 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port req_x  input  8  top-left x of square.
REQ-007 The block SHALL have port req_y  input  7  top-left y of square.
REQ-008 The block SHALL have port req_color  input  3  fill colour.
REQ-009 The block SHALL have port out_x  output  8  pixel x to the VGA adapter.
REQ-010 The block SHALL have port out_y  output  7  pixel y to the VGA adapter.
REQ-011 The block SHALL have port out_color  output  3  pixel colour to the VGA adapter.
REQ-012 The block SHALL have port plot  output  1  write-enable to the VGA adapter.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse after the last pixel of a square.

Function
REQ-014 The block SHALL implement states IDLE, DRAW, DONE.
REQ-015 IDLE SHALL drive req_ready=1, plot=0, done=0, out_x=0, out_y=0, out_color=0.
REQ-016 IDLE with req_valid=1 SHALL latch req_x/req_y/req_color, clear column counter cx and row counter cy, and go to DRAW next cycle.
REQ-017 req_ready SHALL be 0 in DRAW and DONE; req_valid there SHALL be ignored, with no queuing.
REQ-018 DRAW SHALL drive plot=1, out_x=base_x+cx (mod 256), out_y=base_y+cy (mod 128), out_color=latched colour, with all outputs derived only from registers.
REQ-019 Each DRAW cycle SHALL increment cx; at cx=BOX_SIZE-1, cx SHALL wrap to 0 and cy SHALL increment (raster order, row-major).
REQ-020 The DRAW cycle with cx=cy=BOX_SIZE-1 SHALL be the last; the next state SHALL be DONE.
REQ-021 DONE SHALL drive done=1, plot=0 for exactly one cycle, then go to IDLE.
REQ-022 Latency SHALL be: first plot 1 cycle after the accept cycle, exactly BOX_SIZE*BOX_SIZE consecutive plot cycles, done on the following cycle, req_ready=1 on the cycle after done.
REQ-023 BOX_SIZE=1 SHALL give exactly one plot cycle, then DONE.
REQ-024 Coordinate sums that overflow SHALL wrap modulo field width unless clipping is compiled in.

Reset
REQ-025 reset=1 SHALL, at the next rising edge, force IDLE, clear cx, cy and latched fields, and drive plot=0, done=0, out_x=0, out_y=0, out_color=0.
REQ-026 reset asserted mid-DRAW SHALL abort the square with no further plot pulses; done SHALL NOT pulse for the aborted square.
REQ-027 A request presented in the same cycle as reset SHALL be discarded.

Configuration
REQ-028 Macro BOX_PLOTTER_CLIP_EN, when defined, SHALL compute unwrapped sums (9-bit x, 8-bit y) and force plot=0 for any pixel with x>=160 or y>=120, while out_x/out_y still carry the wrapped values.
REQ-029 With BOX_PLOTTER_CLIP_EN defined, cycle timing SHALL be identical to the unclipped build (clipped pixels still consume a DRAW cycle).
REQ-030 With BOX_PLOTTER_CLIP_EN undefined, plot SHALL be 1 for every DRAW cycle regardless of coordinates.

Verification
REQ-031 BOX_SIZE=4, request x=78, y=54, colour=3'b010 accepted at cycle 0 -> plots cycles 1..16 at x 78..81 in each row, y 54..57 row-major, colour 010; done=1 at cycle 17; req_ready=1 at cycle 18.
REQ-032 req_valid held high during DRAW with a second request x=82, y=58 -> second request ignored until req_ready returns; it is then accepted and drawn only if still presented.
REQ-033 reset pulsed at cycle 6 of a draw -> plot=0 from the next edge, no done pulse, req_ready=1 once reset drops.
REQ-034 x=158, y=118, BOX_SIZE=4 with clip enabled -> 4 plot pulses (x 158..159, y 118..119), 16 DRAW cycles, done at cycle 17; with clip disabled -> 16 plot pulses.
REQ-035 x=254, y=126, BOX_SIZE=4 without clip -> out_x sequence 254,255,0,1; out_y sequence 126,127,0,1.
REQ-036 BOX_SIZE=1, request x=0, y=0, colour=3'b111 -> one plot at cycle 1, done at cycle 2.
